// File: rtl/sram_tdp_bytes.sv
// Single-clock true-dual-port RAM with byte write enables, per-port read-during-write
// mode, optional output register and collision strobe. Parity option: SRAM_TDP_PARITY_EN.
module sram_tdp_bytes #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ABITS  = 9,
  parameter int unsigned MODE_A = 0,
  parameter int unsigned MODE_B = 0,
  parameter int unsigned OUTREG = 0,
  parameter int unsigned DELAY  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               a_en_i,
  input  logic [WIDTH/8-1:0] a_we_i,
  input  logic [ABITS-1:0]   a_adr_i,
  input  logic [WIDTH-1:0]   a_dat_i,
  output logic [WIDTH-1:0]   a_dat_o,
  output logic               a_vld_o,
  input  logic               b_en_i,
  input  logic [WIDTH/8-1:0] b_we_i,
  input  logic [ABITS-1:0]   b_adr_i,
  input  logic [WIDTH-1:0]   b_dat_i,
  output logic [WIDTH-1:0]   b_dat_o,
  output logic               b_vld_o,
  output logic               col_o,
  output logic               a_err_o,
  output logic               b_err_o
);

  localparam int unsigned BYTES      = WIDTH / 8;
  localparam int unsigned DEPTH      = 2 ** ABITS;
  localparam int unsigned WriteFirst = 0;
  localparam int unsigned NoChange   = 2;
  localparam int unsigned ModeA      = (MODE_A > 2) ? 0 : MODE_A;
  localparam int unsigned ModeB      = (MODE_B > 2) ? 0 : MODE_B;

  if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_width_check
    $error("sram_tdp_bytes: WIDTH must be a non-zero multiple of 8");
  end

  // DELAY only shaped output timing in the legacy simulation model; kept for drop-in use.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  // Port 0 is A, port 1 is B.
  logic [1:0]       en;
  logic [BYTES-1:0] we      [2];
  logic [ABITS-1:0] adr     [2];
  logic [WIDTH-1:0] wdat    [2];
  logic [WIDTH-1:0] dat_out [2];
  logic [1:0]       vld_out;
  logic [1:0]       err_out;

  assign en      = {b_en_i, a_en_i};
  assign we[0]   = a_we_i;
  assign we[1]   = b_we_i;
  assign adr[0]  = a_adr_i;
  assign adr[1]  = b_adr_i;
  assign wdat[0] = a_dat_i;
  assign wdat[1] = b_dat_i;

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef SRAM_TDP_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
`endif

  // Port B is written first so port A's later assignment wins on shared bytes.
  always_ff @(posedge clk_i) begin
    for (int p = 1; p >= 0; p--) begin
      for (int k = 0; k < BYTES; k++) begin
        if (rst_ni && en[p] && we[p][k]) begin
          mem[adr[p]][8*k +: 8] <= wdat[p][8*k +: 8];
`ifdef SRAM_TDP_PARITY_EN
          par_mem[adr[p]][k] <= ^wdat[p][8*k +: 8];
`endif
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int unsigned M = (p == 0) ? ModeA : ModeB;

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] old;
    logic [WIDTH-1:0] rdat;
    logic             perr;
    logic             v1_q;
    logic             e1_q;
    logic [WIDTH-1:0] d1_q;

    always_comb begin
      wr   = |we[p];
      old  = mem[adr[p]];
      rd   = en[p] && !(wr && (M == NoChange));
      rdat = old;
      if (wr && (M == WriteFirst)) begin
        for (int k = 0; k < BYTES; k++) begin
          if (we[p][k]) rdat[8*k +: 8] = wdat[p][8*k +: 8];
        end
      end
    end

`ifdef SRAM_TDP_PARITY_EN
    // Bytes replaced by this port's own write carry fresh parity and cannot mismatch.
    always_comb begin
      perr = 1'b0;
      for (int k = 0; k < BYTES; k++) begin
        if (!(wr && (M == WriteFirst) && we[p][k])) begin
          perr = perr | ((^old[8*k +: 8]) ^ par_mem[adr[p]][k]);
        end
      end
    end
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v1_q <= 1'b0;
        e1_q <= 1'b0;
        d1_q <= '0;
      end else begin
        v1_q <= rd;
        e1_q <= rd && perr;
        if (rd) d1_q <= rdat;
      end
    end

    if (OUTREG != 0) begin : g_outreg
      logic             v2_q;
      logic             e2_q;
      logic [WIDTH-1:0] d2_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v2_q <= 1'b0;
          e2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          e2_q <= e1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end

      assign dat_out[p] = d2_q;
      assign vld_out[p] = v2_q;
      assign err_out[p] = e2_q;
    end else begin : g_direct
      assign dat_out[p] = d1_q;
      assign vld_out[p] = v1_q;
      assign err_out[p] = e1_q;
    end
  end

  logic col_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= 1'b0;
    end else begin
      col_q <= a_en_i && b_en_i && (a_adr_i == b_adr_i) && ((|a_we_i) || (|b_we_i));
    end
  end

  assign a_dat_o = dat_out[0];
  assign a_vld_o = vld_out[0];
  assign a_err_o = err_out[0];
  assign b_dat_o = dat_out[1];
  assign b_vld_o = vld_out[1];
  assign b_err_o = err_out[1];
  assign col_o   = col_q;

endmodule

// File: tb/tb_sram_tdp_bytes.sv
// Scoreboard bench for sram_tdp_bytes: two instances (different modes / OUTREG) share
// stimulus; a word-array reference model predicts every read pulse and collision strobe.
module tb_sram_tdp_bytes;

  localparam int unsigned W  = 32;
  localparam int unsigned AB = 9;
  localparam int unsigned BY = 4;

  // Slot s = 2*instance + port; instance 0: A WRITE_FIRST, B READ_FIRST, latency 1;
  // instance 1: A NO_CHANGE, B WRITE_FIRST, latency 2.
  int mode [4] = '{0, 1, 2, 0};
  int lat  [4] = '{1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [BY-1:0] a_we, b_we;
  logic [AB-1:0] a_adr, b_adr;
  logic [W-1:0]  a_wd, b_wd;
  logic [W-1:0]  rdat [4];
  logic [3:0]    vld;
  logic [3:0]    err;
  logic [1:0]    col;

  sram_tdp_bytes #(.WIDTH(W), .ABITS(AB), .MODE_A(0), .MODE_B(1), .OUTREG(0), .DELAY(3)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_en_i(a_en), .a_we_i(a_we), .a_adr_i(a_adr), .a_dat_i(a_wd),
    .a_dat_o(rdat[0]), .a_vld_o(vld[0]),
    .b_en_i(b_en), .b_we_i(b_we), .b_adr_i(b_adr), .b_dat_i(b_wd),
    .b_dat_o(rdat[1]), .b_vld_o(vld[1]),
    .col_o(col[0]), .a_err_o(err[0]), .b_err_o(err[1])
  );

  sram_tdp_bytes #(.WIDTH(W), .ABITS(AB), .MODE_A(2), .MODE_B(0), .OUTREG(1), .DELAY(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_en_i(a_en), .a_we_i(a_we), .a_adr_i(a_adr), .a_dat_i(a_wd),
    .a_dat_o(rdat[2]), .a_vld_o(vld[2]),
    .b_en_i(b_en), .b_we_i(b_we), .b_adr_i(b_adr), .b_dat_i(b_wd),
    .b_dat_o(rdat[3]), .b_vld_o(vld[3]),
    .col_o(col[1]), .a_err_o(err[2]), .b_err_o(err[3])
  );

  typedef struct {
    int         slot;
    int         cyc;
    logic [W-1:0] dat;
    logic       err;
  } exp_t;

  exp_t         sb [$];
  bit           exp_col [int];
  logic [W-1:0] last_dat [4];
  logic [W-1:0] mdl_mem [2**AB];
  logic [BY-1:0] mdl_par [2**AB];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, req);
    end
  endfunction

  function automatic int find_slot(int s);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].slot == s) return i;
    end
    return -1;
  endfunction

  // Reference model: evaluated once per edge from the inputs about to be sampled.
  task automatic model_step();
    logic [W-1:0] old [2];
    logic          pen [2];
    logic [BY-1:0] pwe [2];
    logic [AB-1:0] padr [2];
    logic [W-1:0]  pdat [2];
    pen  = '{a_en, b_en};
    pwe  = '{a_we, b_we};
    padr = '{a_adr, b_adr};
    pdat = '{a_wd, b_wd};
    old[0] = mdl_mem[a_adr];
    old[1] = mdl_mem[b_adr];
    for (int s = 0; s < 4; s++) begin
      int   p;
      bit   own_new;
      exp_t e;
      p = s % 2;
      if (!pen[p]) continue;
      if (pwe[p] != 0 && mode[s] == 2) continue;
      own_new = (pwe[p] != 0) && (mode[s] == 0);
      e.slot = s;
      e.cyc  = cyc + lat[s];
      e.dat  = old[p];
      e.err  = 1'b0;
      for (int k = 0; k < BY; k++) begin
        if (own_new && pwe[p][k]) begin
          e.dat[8*k +: 8] = pdat[p][8*k +: 8];
        end else begin
`ifdef SRAM_TDP_PARITY_EN
          if ((^old[p][8*k +: 8]) != mdl_par[padr[p]][k]) e.err = 1'b1;
`endif
        end
      end
      sb.push_back(e);
    end
    if (a_en && b_en && a_adr == b_adr && (a_we != 0 || b_we != 0)) exp_col[cyc + 1] = 1'b1;
    // Each byte takes A's data if A writes it, else B's if B writes it.
    for (int k = 0; k < BY; k++) begin
      if (b_en && b_we[k]) begin
        mdl_mem[b_adr][8*k +: 8] = b_wd[8*k +: 8];
        mdl_par[b_adr][k] = ^b_wd[8*k +: 8];
      end
      if (a_en && a_we[k]) begin
        mdl_mem[a_adr][8*k +: 8] = a_wd[8*k +: 8];
        mdl_par[a_adr][k] = ^a_wd[8*k +: 8];
      end
    end
  endtask

  // Called at posedge+#1; applies one cycle of stimulus and returns at the next posedge+#1.
  task automatic step(input logic ae, input logic [BY-1:0] awe, input logic [AB-1:0] aadr,
                      input logic [W-1:0] ad, input logic be, input logic [BY-1:0] bwe,
                      input logic [AB-1:0] badr, input logic [W-1:0] bd);
    a_en = ae; a_we = awe; a_adr = aadr; a_wd = ad;
    b_en = be; b_we = bwe; b_adr = badr; b_wd = bd;
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [AB-1:0] rand_adr();
    if ($urandom_range(0, 7) == 0) return 9'h1FF;
    return 9'($urandom_range(0, 31));
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int s = 0; s < 4; s++) begin
        int idx;
        idx = find_slot(s);
        if (vld[s]) begin
          if (idx < 0) begin
            chk($sformatf("spurious_vld[%0d]", s), {31'b0, vld[s]}, '0);
          end else begin
            chk($sformatf("vld_cycle[%0d]", s), cyc, sb[idx].cyc);
            chk($sformatf("dat[%0d]", s), rdat[s], sb[idx].dat);
            chk($sformatf("err[%0d]", s), {31'b0, err[s]}, {31'b0, sb[idx].err});
            last_dat[s] = sb[idx].dat;
            sb.delete(idx);
          end
        end else if (idx >= 0 && sb[idx].cyc <= cyc) begin
          chk($sformatf("missing_vld[%0d]", s), {31'b0, vld[s]}, 32'd1);
          sb.delete(idx);
        end else begin
          chk($sformatf("hold_dat[%0d]", s), rdat[s], last_dat[s]);
          chk($sformatf("idle_err[%0d]", s), {31'b0, err[s]}, '0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("col[%0d]", i), {31'b0, col[i]},
            {31'b0, exp_col.exists(cyc) ? exp_col[cyc] : 1'b0});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_we = '0; a_adr = '0; a_wd = '0;
    b_en = 1'b0; b_we = '0; b_adr = '0; b_wd = '0;
    for (int s = 0; s < 4; s++) last_dat[s] = '0;
    repeat (2) @(posedge clk);
    #1;
    // Enables asserted during reset must be ignored.
    step(1'b1, 4'hF, 9'h005, 32'h0BAD0BAD, 1'b1, 4'h0, 9'h005, '0);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst_dat[%0d]", s), rdat[s], '0);
      chk($sformatf("rst_vld[%0d]", s), {31'b0, vld[s]}, '0);
      chk($sformatf("rst_err[%0d]", s), {31'b0, err[s]}, '0);
    end
    chk("rst_col0", {31'b0, col[0]}, '0);
    chk("rst_col1", {31'b0, col[1]}, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Give every address the bench touches a known value (port A only).
    for (int i = 0; i < 32; i++) step(1'b1, 4'hF, 9'(i), $urandom, 1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 9'h1FF, $urandom, 1'b0, '0, '0, '0);

    step(1'b1, 4'hF, 9'h005, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'h0, 9'h005, '0);
    step(1'b1, 4'hF, 9'h010, 32'h11223344, 1'b0, '0, '0, '0);
    step(1'b1, 4'b0101, 9'h010, 32'hAABBCCDD, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'h0, 9'h010, '0);
    step(1'b1, 4'hF, 9'h020, 32'h00000001, 1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 9'h020, 32'h00000002, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'hF, 9'h020, 32'h00000003);
    step(1'b1, 4'h0, 9'h020, '0, 1'b1, 4'h0, 9'h020, '0);
    step(1'b1, 4'hF, 9'h1FF, 32'hAAAAAAAA, 1'b1, 4'hF, 9'h1FF, 32'hBBBBBBBB);
    step(1'b1, 4'h0, 9'h1FF, '0, 1'b1, 4'h0, 9'h1FF, '0);
    step(1'b1, 4'hF, 9'h1FF, 32'h12345678, 1'b1, 4'h0, 9'h1FF, '0);
    step(1'b1, 4'b0011, 9'h007, 32'h5555AAAA, 1'b1, 4'b0110, 9'h007, 32'h99887766);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, '0, 1'b1, 4'h0, 9'(i), '0);

    for (int n = 0; n < 400; n++) begin
      logic [AB-1:0] aa, ba;
      aa = rand_adr();
      ba = ($urandom_range(0, 2) == 0) ? aa : rand_adr();
      if (n == 200) begin
        // Mid-stream reset: anything in flight is dropped.
        sb.delete();
        exp_col.delete();
        for (int s = 0; s < 4; s++) last_dat[s] = '0;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
          chk($sformatf("midrst_dat[%0d]", s), rdat[s], '0);
          chk($sformatf("midrst_vld[%0d]", s), {31'b0, vld[s]}, '0);
        end
        #(8);
        repeat (3) step(1'b1, 4'hF, aa, $urandom, 1'b1, 4'hF, ba, $urandom);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           aa, $urandom,
           $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           ba, $urandom);
    end

`ifdef SRAM_TDP_PARITY_EN
    step(1'b1, 4'hF, 9'h003, 32'h000000FF, 1'b0, '0, '0, '0);
    repeat (3) idle();
    dut0.mem[3][0] = ~dut0.mem[3][0];
    dut1.mem[3][0] = ~dut1.mem[3][0];
    mdl_mem[3][0] = ~mdl_mem[3][0];
    step(1'b1, 4'h0, 9'h003, '0, 1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 9'h003, 32'h000000FF, 1'b0, '0, '0, '0);
    step(1'b1, 4'h0, 9'h003, '0, 1'b0, '0, '0, '0);
`endif

    repeat (4) idle();
    chk("scoreboard_drained", sb.size(), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
